pc_branch: RTL and testbench

//  Branch-target adder for the CPU datapath, used in the fetch/decode path beside the PC+4 adder.
//  - Computes the target as pc_plus_4 + (imm_ext << 2), modulo 2^WIDTH.
//  - Provides the combinational target for the same-cycle PC mux.
//  - Provides a registered copy with valid and wrap status for the pipeline/trace.

---
 rtl/pc_branch_if.sv | 24 ++
 rtl/pc_branch.sv | 52 +++++
 tb/tb_pc_branch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pc_branch_if.sv
// pc_branch_if: operand/result bundle for the branch-target adder.
// PC_BRANCH_ALIGN_CHECK_EN adds misaligned_q.
interface pc_branch_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] pc_plus_4;
  logic [WIDTH-1:0] imm_ext;
  logic             in_valid;
  logic [WIDTH-1:0] pc_branch_out;
  logic             wrap;
  logic [WIDTH-1:0] pc_branch_q;
  logic             out_valid;
  logic             wrap_q;
`ifdef PC_BRANCH_ALIGN_CHECK_EN
  logic             misaligned_q;
  modport master (output pc_plus_4, imm_ext, in_valid,
                  input pc_branch_out, wrap, pc_branch_q, out_valid, wrap_q, misaligned_q);
  modport slave  (input pc_plus_4, imm_ext, in_valid,
                  output pc_branch_out, wrap, pc_branch_q, out_valid, wrap_q, misaligned_q);
`else
  modport master (output pc_plus_4, imm_ext, in_valid,
                  input pc_branch_out, wrap, pc_branch_q, out_valid, wrap_q);
  modport slave  (input pc_plus_4, imm_ext, in_valid,
                  output pc_branch_out, wrap, pc_branch_q, out_valid, wrap_q);
`endif
endinterface

// File: rtl/pc_branch.sv
// pc_branch: branch-target adder pc_plus_4 + (imm_ext << SHIFT) with registered copy.
// PC_BRANCH_ALIGN_CHECK_EN adds a registered misaligned-PC flag.
module pc_branch #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 2
) (
  input logic clk,
  input logic reset,
  pc_branch_if.slave bus
);
  logic [WIDTH-1:0] off;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             wrap;
  logic [WIDTH-1:0] tgt_d, tgt_q;
  logic             valid_d, valid_q;
  logic             wrap_d, wrap_q;
  always_comb begin
    off = bus.imm_ext << SHIFT;
    {cout, sum} = {1'b0, bus.pc_plus_4} + {1'b0, off};
    // positive offset with carry, or negative offset without carry, crossed the boundary
    wrap = off[WIDTH-1] ^ cout;
    valid_d = bus.in_valid;
    tgt_d = bus.in_valid ? sum : tgt_q;
    wrap_d = bus.in_valid ? wrap : wrap_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q <= '0;
      valid_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      valid_q <= valid_d;
      wrap_q <= wrap_d;
    end
  end
  assign bus.pc_branch_out = sum;
  assign bus.wrap = wrap;
  assign bus.pc_branch_q = tgt_q;
  assign bus.out_valid = valid_q;
  assign bus.wrap_q = wrap_q;
`ifdef PC_BRANCH_ALIGN_CHECK_EN
  logic mis_d, mis_q;
  always_comb mis_d = bus.in_valid & (bus.pc_plus_4[1:0] != 2'b00);
  always_ff @(posedge clk) begin
    if (reset) mis_q <= 1'b0;
    else mis_q <= mis_d;
  end
  assign bus.misaligned_q = mis_q;
`endif
endmodule

// File: tb/tb_pc_branch.sv
// tb_pc_branch: directed vectors, registered-stage sequences and randomized model check.
module tb_pc_branch;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int passed = 0;
  pc_branch_if #(.WIDTH(32)) bus();
  pc_branch #(.WIDTH(32), .SHIFT(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] exp_out;
    logic        exp_wrap;
  } vec_t;

  logic [31:0] m_tgt_q;
  logic        m_valid_q, m_wrap_q, m_mis_q;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // target and wrap from signed arithmetic on the full address range
  function automatic logic [32:0] model(logic [31:0] pc, logic [31:0] imm);
    logic [31:0] o;
    longint s;
    o = imm << 2;
    s = longint'(pc) + longint'($signed(o));
    return {(s < 0) || (s >= 64'h1_0000_0000), s[31:0]};
  endfunction

  task automatic check_comb(string name);
    logic [32:0] m;
    m = model(bus.pc_plus_4, bus.imm_ext);
    check({name, ".out"}, bus.pc_branch_out, m[31:0]);
    check({name, ".wrap"}, {31'b0, bus.wrap}, {31'b0, m[32]});
  endtask

  task automatic check_regs(string name);
    check({name, ".pc_q"}, bus.pc_branch_q, m_tgt_q);
    check({name, ".valid"}, {31'b0, bus.out_valid}, {31'b0, m_valid_q});
    check({name, ".wrap_q"}, {31'b0, bus.wrap_q}, {31'b0, m_wrap_q});
`ifdef PC_BRANCH_ALIGN_CHECK_EN
    check({name, ".mis_q"}, {31'b0, bus.misaligned_q}, {31'b0, m_mis_q});
`endif
  endtask

  task automatic step(logic r, logic iv, logic [31:0] pc, logic [31:0] imm);
    logic [32:0] m;
    @(negedge clk);
    reset = r;
    bus.in_valid = iv;
    bus.pc_plus_4 = pc;
    bus.imm_ext = imm;
    m = model(pc, imm);
    @(posedge clk);
    if (r) begin
      m_tgt_q = '0; m_valid_q = 1'b0; m_wrap_q = 1'b0; m_mis_q = 1'b0;
    end else begin
      m_valid_q = iv;
      m_mis_q = iv && (pc % 4 != 0);
      if (iv) begin
        m_tgt_q = m[31:0];
        m_wrap_q = m[32];
      end
    end
    #1;
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{32'h0000_1004, 32'h0000_0001, 32'h0000_1008, 1'b0};
    vecs[1] = '{32'h0000_2008, 32'h0000_0100, 32'h0000_2408, 1'b0};
    vecs[2] = '{32'h0000_300C, 32'hFFFF_FFFC, 32'h0000_2FFC, 1'b0};
    vecs[3] = '{32'h0000_4010, 32'h0000_0000, 32'h0000_4010, 1'b0};
    vecs[4] = '{32'h7FFF_FFFC, 32'h3FFF_FFFF, 32'h7FFF_FFF8, 1'b0};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0001, 32'h0000_0000, 1'b1};

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.pc_plus_4 = '0;
    bus.imm_ext = '0;

    // reset held two cycles
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_2008, 32'h0000_0100);
    check("rst.pc_q", bus.pc_branch_q, 32'h0);
    check("rst.valid", {31'b0, bus.out_valid}, 32'h0);
    check("rst.wrap_q", {31'b0, bus.wrap_q}, 32'h0);

    // combinational vectors, applied while reset is asserted
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.pc_plus_4 = vecs[i].pc;
      bus.imm_ext = vecs[i].imm;
      #1;
      check($sformatf("vec%0d.out", i), bus.pc_branch_out, vecs[i].exp_out);
      check($sformatf("vec%0d.wrap", i), {31'b0, bus.wrap}, {31'b0, vecs[i].exp_wrap});
    end

    // registered stage: capture, hold, reset-wins
    step(1'b0, 1'b1, 32'h0000_2008, 32'h0000_0100);
    check("reg.pc_q", bus.pc_branch_q, 32'h0000_2408);
    check("reg.valid", {31'b0, bus.out_valid}, 32'h1);
    step(1'b0, 1'b0, 32'h0000_4010, 32'h0000_0040);
    check("hold.pc_q", bus.pc_branch_q, 32'h0000_2408);
    check("hold.valid", {31'b0, bus.out_valid}, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0001);
    check("wrapcap.pc_q", bus.pc_branch_q, 32'h0);
    check("wrapcap.wrap_q", {31'b0, bus.wrap_q}, 32'h1);
    step(1'b0, 1'b0, 32'h0000_1004, 32'h0000_0001);
    check("wraphold.wrap_q", {31'b0, bus.wrap_q}, 32'h1);
    step(1'b1, 1'b1, 32'h0000_2008, 32'h0000_0100);
    check("rstwin.pc_q", bus.pc_branch_q, 32'h0);
    check("rstwin.valid", {31'b0, bus.out_valid}, 32'h0);
    check("rstwin.wrap_q", {31'b0, bus.wrap_q}, 32'h0);
`ifdef PC_BRANCH_ALIGN_CHECK_EN
    step(1'b0, 1'b1, 32'h0000_1006, 32'h0000_0001);
    check("mis.set", {31'b0, bus.misaligned_q}, 32'h1);
    step(1'b0, 1'b0, 32'h0000_1006, 32'h0000_0001);
    check("mis.clr", {31'b0, bus.misaligned_q}, 32'h0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] pc, imm;
      logic r, iv;
      r = ($urandom_range(0, 24) == 0);
      iv = ($urandom_range(0, 3) != 0);
      pc = $urandom;
      case ($urandom_range(0, 3))
        0: imm = $urandom_range(0, 64);
        1: imm = -$urandom_range(0, 64);
        2: begin pc = 32'hFFFF_FF00 | ($urandom & 32'hFC); imm = $urandom_range(0, 128); end
        default: imm = $urandom;
      endcase
      step(r, iv, pc, imm);
      check_regs($sformatf("rnd%0d", i));
      check_comb($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
